// File: rtl/gshare_predictor_pkg.sv
// Shared constants, types and decode helpers for the gshare branch predictor.
// Holds the default predictor geometry, the RV32 opcode constants used by the
// fetch-side decoder, the predictor FSM state type and the B/J immediate
// extraction functions.
package gshare_predictor_pkg;

    localparam int DATA_W              = 32;
    localparam int OPCODE_MSB          = 6;
    localparam int OPCODE_LSB          = 0;
    localparam int PRED_IDX_W_DEFAULT  = 10;
    localparam int PRED_CNT_W_DEFAULT  = 2;
    localparam int PRED_HIST_W_DEFAULT = 8;

    localparam logic [6:0] JAL_TYPE = 7'b1101111;
    localparam logic [6:0] B_TYPE   = 7'b1100011;
    localparam logic       TRUE     = 1'b1;
    localparam logic       FALSE    = 1'b0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pred_state_e;

    // Sign-extended B-type branch offset.
    function automatic logic [DATA_W-1:0] imm_b(input logic [DATA_W-1:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    // Sign-extended J-type (JAL) offset.
    function automatic logic [DATA_W-1:0] imm_j(input logic [DATA_W-1:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch/commit bundle between the fetcher, the ROB and the predictor.
// master: fetcher + ROB side (drives instruction, PC and commit info,
//         receives the prediction).
// slave : predictor side.
interface gshare_predictor_if;
    logic        instr_valid;
    logic [31:0] instr_from_IC;
    logic [31:0] cur_pc;
    logic        if_jump;
    logic [31:0] predict_pc;
    logic        rob_commit_br;
    logic [31:0] rob_commit_pc;
    logic        rob_commit_taken;

    modport master (
        output instr_valid, instr_from_IC, cur_pc,
        output rob_commit_br, rob_commit_pc, rob_commit_taken,
        input  if_jump, predict_pc
    );

    modport slave (
        input  instr_valid, instr_from_IC, cur_pc,
        input  rob_commit_br, rob_commit_pc, rob_commit_taken,
        output if_jump, predict_pc
    );
endinterface

// File: rtl/gshare_predictor_sat_counter_next.sv
// sat_counter_next: combinational next value of a CNT_W-bit saturating
// counter. Ports: cnt (current value), inc (1 = count up, 0 = count down),
// cnt_next (updated value, clamped at 0 and 2**CNT_W-1).
module sat_counter_next #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_next
);
    always_comb begin
        cnt_next = cnt;
        if (inc) begin
            if (cnt != '1) cnt_next = cnt + CNT_W'(1);
        end else begin
            if (cnt != '0) cnt_next = cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: fetch-stage direction/target predictor with a PHT of
// saturating counters trained at ROB commit.
// Ports: clk, rst (sync, active high), rdy (global enable, low freezes all
// state), init_done (high once the PHT init sweep has finished),
// bus (gshare_predictor_if.slave: fetch instruction/PC in, if_jump and
// predict_pc out combinationally, commit branch PC/outcome in).
// Build option: define GSHARE_EN to XOR the global history into the PHT
// index; otherwise the predictor is bimodal and has no history register.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int IDX_W  = PRED_IDX_W_DEFAULT,
    parameter int CNT_W  = PRED_CNT_W_DEFAULT,
    parameter int HIST_W = PRED_HIST_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    output logic init_done,
    gshare_predictor_if.slave bus
);
    localparam int DEPTH = 1 << IDX_W;
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

    pred_state_e      state_reg, state_next;
    logic [IDX_W-1:0] sweep_ptr_reg, sweep_ptr_next;
    logic [IDX_W-1:0] hist_ext;
    logic [IDX_W-1:0] fetch_idx, commit_idx;
    logic [CNT_W-1:0] fetch_cnt, commit_cnt, commit_cnt_next;
    logic             pht_we;
    logic [IDX_W-1:0] pht_waddr;
    logic [CNT_W-1:0] pht_wdata;
    logic             train_en;

    logic [CNT_W-1:0] pht_mem [DEPTH];

    logic unused_commit_pc_bits;
    assign unused_commit_pc_bits = ^{bus.rob_commit_pc[31:IDX_W+2], bus.rob_commit_pc[1:0]};

`ifdef GSHARE_EN
    logic [HIST_W-1:0] ghr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (train_en) begin
            ghr_reg <= {ghr_reg[HIST_W-2:0], bus.rob_commit_taken};
        end
    end

    assign hist_ext = IDX_W'(ghr_reg);
`else
    assign hist_ext = '0;
`endif

    // Both paths use the history as it stands before this cycle's commit.
    assign fetch_idx  = bus.cur_pc[IDX_W+1:2] ^ hist_ext;
    assign commit_idx = bus.rob_commit_pc[IDX_W+1:2] ^ hist_ext;
    assign fetch_cnt  = pht_mem[fetch_idx];
    assign commit_cnt = pht_mem[commit_idx];

    sat_counter_next #(.CNT_W(CNT_W)) u_sat (
        .cnt      (commit_cnt),
        .inc      (bus.rob_commit_taken),
        .cnt_next (commit_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            sweep_ptr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_ptr_reg <= sweep_ptr_next;
        end
    end

    // Single PHT write port shared by the init sweep and commit training.
    always_comb begin
        state_next     = state_reg;
        sweep_ptr_next = sweep_ptr_reg;
        pht_we         = FALSE;
        pht_waddr      = commit_idx;
        pht_wdata      = commit_cnt_next;
        train_en       = FALSE;
        case (state_reg)
            ST_INIT: begin
                if (rdy) begin
                    pht_we         = TRUE;
                    pht_waddr      = sweep_ptr_reg;
                    pht_wdata      = CNT_INIT;
                    sweep_ptr_next = sweep_ptr_reg + IDX_W'(1);
                    if (sweep_ptr_reg == '1) state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rdy && bus.rob_commit_br) begin
                    pht_we   = TRUE;
                    train_en = TRUE;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Write-only port; reads above are asynchronous and see the old value.
    always_ff @(posedge clk) begin
        if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
    end

    logic [6:0]  opcode;
    logic [31:0] seq_pc, target_pc;
    logic        jump_c;

    assign opcode = bus.instr_from_IC[OPCODE_MSB:OPCODE_LSB];
    assign seq_pc = bus.cur_pc + 32'd4;

    always_comb begin
        jump_c    = FALSE;
        target_pc = seq_pc;
        if (bus.instr_valid) begin
            if (opcode == JAL_TYPE) begin
                jump_c    = TRUE;
                target_pc = bus.cur_pc + imm_j(bus.instr_from_IC);
            end else if (opcode == B_TYPE) begin
                target_pc = bus.cur_pc + imm_b(bus.instr_from_IC);
                // Table contents are not trusted until the sweep finishes.
                jump_c    = (state_reg == ST_RUN) && fetch_cnt[CNT_W-1];
            end
        end
    end

    assign bus.if_jump    = jump_c;
    assign bus.predict_pc = jump_c ? target_pc : seq_pc;
    assign init_done      = (state_reg == ST_RUN);

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor (IDX_W=4, CNT_W=2, HIST_W=4).
// Works in both builds: the reference model honours GSHARE_EN.
module tb_gshare_predictor;
    localparam int IDX_W = 4;
    localparam int CNT_W = 2;
    localparam int HIST_W = 4;

    logic clk, rst, rdy, init_done;
    gshare_predictor_if bus_if();

    gshare_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W), .HIST_W(HIST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .init_done (init_done),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct packed { logic j; logic [31:0] pc; } pred_t;
    pred_t sb_q[$];

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exp_j;
        logic [31:0] exp_pc;
        string       name;
    } vec_t;
    vec_t vecs[9];

    // Reference model of the table and history.
    int         m_pht[16];
    logic [3:0] m_ghr;

    function automatic logic [31:0] enc_b(input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] i;
        i = imm[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
`ifdef GSHARE_EN
        return int'(pc[5:2] ^ m_ghr);
`else
        return int'(pc[5:2]);
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        m_ghr = 4'd0;
    endtask

    task automatic m_train(input logic [31:0] pc, input logic taken);
        int i;
        i = m_idx(pc);
        if (taken && m_pht[i] < 3) m_pht[i] = m_pht[i] + 1;
        if (!taken && m_pht[i] > 0) m_pht[i] = m_pht[i] - 1;
`ifdef GSHARE_EN
        m_ghr = {m_ghr[2:0], taken};
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("[txn] %s = %0d ok", name, act);
        end
    endtask

    // Drive a fetch, queue its expected prediction, then compare once settled.
    task automatic chk_pred(input string name, input logic valid, input logic [31:0] instr,
                            input logic [31:0] pc, input logic exp_j, input logic [31:0] exp_pc);
        pred_t e;
        bus_if.instr_valid   = valid;
        bus_if.instr_from_IC = instr;
        bus_if.cur_pc        = pc;
        sb_q.push_back('{j: exp_j, pc: exp_pc});
        #1;
        e = sb_q.pop_front();
        total++;
        if (bus_if.if_jump !== e.j || bus_if.predict_pc !== e.pc) begin
            bad++;
            $display("FAIL %s: got jump=%0b pc=%h, want jump=%0b pc=%h",
                     name, bus_if.if_jump, bus_if.predict_pc, e.j, e.pc);
        end else begin
            $display("[txn] %s jump=%0b pc=%h ok", name, e.j, e.pc);
        end
    endtask

    // B-type prediction checked against the model table.
    task automatic chk_b_model(input string name, input logic [31:0] pc, input int imm);
        logic ej;
        ej = (m_pht[m_idx(pc)] >= 2);
        chk_pred(name, 1'b1, enc_b(imm), pc, ej, ej ? pc + 32'(imm) : pc + 32'd4);
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic taken);
        bus_if.rob_commit_br    = 1'b1;
        bus_if.rob_commit_pc    = pc;
        bus_if.rob_commit_taken = taken;
        step();
        bus_if.rob_commit_br = 1'b0;
        m_train(pc, taken);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic wait_init(input int start, input int exp);
        int n;
        n = start;
        while (init_done !== 1'b1 && n < start + 60) begin
            step();
            n++;
        end
        chk_int("sweep_cycles", n, exp);
    endtask

    task automatic set_vec(input int k, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                           input logic ej, input logic [31:0] epc, input string nm);
        vecs[k].valid = v; vecs[k].instr = ins; vecs[k].pc = pc;
        vecs[k].exp_j = ej; vecs[k].exp_pc = epc; vecs[k].name = nm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expectations hold with every counter weakly not-taken.
        set_vec(0, 1'b1, enc_j(-8),       32'h1000,     1'b1, 32'hFF8,   "jal_neg");
        set_vec(1, 1'b1, enc_b(16),       32'h100,      1'b0, 32'h104,   "b_weak_nt");
        set_vec(2, 1'b1, enc_b(-32),      32'h200,      1'b0, 32'h204,   "b_neg_nt");
        set_vec(3, 1'b1, 32'h00000013,    32'h400,      1'b0, 32'h404,   "other_op");
        set_vec(4, 1'b0, enc_j(64),       32'h500,      1'b0, 32'h504,   "invalid_jal");
        set_vec(5, 1'b1, enc_j(8),        32'hFFFFFFFC, 1'b1, 32'h4,     "jal_wrap");
        set_vec(6, 1'b1, 32'h00000013,    32'hFFFFFFFC, 1'b0, 32'h0,     "seq_wrap");
        set_vec(7, 1'b1, enc_j(2048),     32'h2000,     1'b1, 32'h2800,  "jal_bit11");
        set_vec(8, 1'b1, enc_j(32'h7F000), 32'h0,       1'b1, 32'h7F000, "jal_hi_imm");

        rst = 1'b1; rdy = 1'b1;
        bus_if.instr_valid = 1'b0; bus_if.instr_from_IC = '0; bus_if.cur_pc = '0;
        bus_if.rob_commit_br = 1'b0; bus_if.rob_commit_pc = '0; bus_if.rob_commit_taken = 1'b0;

        // Reset, partial sweep, reset again: sweep must restart from 0.
        do_reset(3);
        chk_int("init_done_reset", int'(init_done), 0);
        repeat (5) step();
        do_reset(1);
        chk_int("init_done_restart", int'(init_done), 0);
        wait_init(0, 16);

        for (int k = 0; k < 9; k++)
            chk_pred(vecs[k].name, vecs[k].valid, vecs[k].instr, vecs[k].pc, vecs[k].exp_j, vecs[k].exp_pc);
        step();
        for (int i = 0; i < 16; i++) begin
            chk_b_model($sformatf("swept_entry_%0d", i), 32'(i * 4), 8);
            if (i % 4 == 3) step();
        end
        do_commit(32'h8, 1'b1);
        chk_b_model("one_taken_flips", 32'h8, 8);

        // Saturation at zero.
        for (int i = 0; i < 3; i++) begin
            do_commit(32'h200, 1'b0);
            chk_b_model($sformatf("zero_sat_nt_%0d", i), 32'h200, 16);
        end
        do_commit(32'h200, 1'b1);
        chk_b_model("zero_sat_then_t", 32'h200, 16);

        // Saturation at the top.
        for (int i = 0; i < 5; i++) begin
            do_commit(32'h100, 1'b1);
            chk_b_model($sformatf("top_sat_t_%0d", i), 32'h100, 16);
        end
        do_commit(32'h100, 1'b0);
        chk_b_model("top_sat_then_nt", 32'h100, 16);

        // Reset from RUN: JAL still predicted, B-type forced not-taken,
        // commits ignored, rdy low stalls the sweep.
        do_reset(1);
        chk_pred("init_jal", 1'b1, enc_j(-8), 32'h1000, 1'b1, 32'hFF8);
        chk_pred("init_b_forced_nt", 1'b1, enc_b(16), 32'h100, 1'b0, 32'h104);
        bus_if.rob_commit_br = 1'b1; bus_if.rob_commit_pc = 32'h0; bus_if.rob_commit_taken = 1'b1;
        step();
        bus_if.rob_commit_br = 1'b0;
        rdy = 1'b0;
        repeat (3) step();
        chk_int("init_done_stalled", int'(init_done), 0);
        rdy = 1'b1;
        wait_init(4, 19);
        do_commit(32'h0, 1'b1);
        chk_b_model("post_init_pc0", 32'h0, 8);
        chk_b_model("post_init_pc4", 32'h4, 8);

        // Commit under rdy low must not train or shift history.
        rdy = 1'b0;
        bus_if.rob_commit_br = 1'b1; bus_if.rob_commit_pc = 32'h14; bus_if.rob_commit_taken = 1'b1;
        step();
        bus_if.rob_commit_br = 1'b0;
        rdy = 1'b1;
        chk_b_model("rdy_low_no_train", 32'h14, 8);
        do_commit(32'h14, 1'b1);
        chk_b_model("rdy_after_pc14", 32'h14, 8);
        chk_b_model("rdy_after_pc18", 32'h18, 8);

        // History-indexed training and same-cycle read of the trained entry.
        do_reset(1);
        wait_init(0, 16);
        do_commit(32'h2C, 1'b0);
        do_commit(32'h2C, 1'b0);
        do_commit(32'h2C, 1'b0);
        do_commit(32'h2C, 1'b1);
        bus_if.rob_commit_br = 1'b1; bus_if.rob_commit_pc = 32'h0; bus_if.rob_commit_taken = 1'b1;
        chk_b_model("same_cycle_old", 32'h0, 8);
        step();
        bus_if.rob_commit_br = 1'b0;
        m_train(32'h0, 1'b1);
        chk_b_model("hist_pc0", 32'h0, 8);
        chk_b_model("hist_pc4", 32'h4, 8);
        chk_b_model("hist_pc8", 32'h8, 8);
        chk_b_model("hist_pc2c", 32'h2C, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
